pipe_out_fifo: RTL and testbench

PIPE_OUT_FIFO -- requirements
Module: pipe_out_fifo

---
 rtl/pipe_out_fifo.sv | 94 +++++++++
 tb/tb_pipe_out_fifo.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_out_fifo.sv
// Output queue behind a valid-only pipeline: circular buffer with a sticky drop flag.
// Define PIPE_OUT_FIFO_BYPASS_EN to let words fall through combinationally while the queue is empty.
module pipe_out_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int AFULL_LVL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;

    logic empty, full, pop_mem, wr_en, ovf_evt, bypass_take;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_mem = !empty && out_ready;

`ifdef PIPE_OUT_FIFO_BYPASS_EN
    // An empty queue hands the incoming word straight to the consumer.
    assign bypass_take = empty && in_valid && out_ready;
    assign out_valid   = !empty || in_valid;
    assign out_data    = empty ? in_data : mem_q[rd_ptr_q];
`else
    assign bypass_take = 1'b0;
    assign out_valid   = !empty;
    assign out_data    = mem_q[rd_ptr_q];
`endif

    // A full queue still accepts a word if the head leaves in the same cycle.
    assign wr_en   = in_valid && !bypass_take && (!full || pop_mem);
    assign ovf_evt = in_valid && full && !pop_mem;

    assign count       = count_q;
    assign almost_full = (count_q >= CW'(AFULL_LVL));
    assign overflow    = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_mem)
            rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, pop_mem})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (ovf_evt)
            overflow_d = 1'b1;
        else if (clr_overflow)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_pipe_out_fifo.sv
// Directed bench for pipe_out_fifo with a queue scoreboard holding the expected stored words.
module tb_pipe_out_fifo;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 4;
    localparam int AFULL_LVL = 2;
    localparam int CW        = $clog2(DEPTH) + 1;
`ifdef PIPE_OUT_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             almost_full;
    logic             overflow;
    logic             clr_overflow;

    pipe_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    bit          m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: handshake checked mid-cycle, registered state after the edge.
    task automatic cycle(input bit iv, input logic [31:0] d, input bit rdy, input bit clr = 1'b0);
        int          n;
        bit          exp_valid, pop, bypassed, popped_mem, evt;
        logic [31:0] e;
        in_valid     = iv;
        in_data      = d;
        out_ready    = rdy;
        clr_overflow = clr;
        @(negedge clk);
        n          = exp_q.size();
        exp_valid  = (n != 0) || (BYP && iv);
        pop        = exp_valid && rdy;
        bypassed   = BYP && (n == 0) && iv && rdy;
        popped_mem = (n != 0) && rdy;
        evt        = 1'b0;
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (pop) begin
            e = (n == 0) ? d : exp_q.pop_front();
            chk("out_data", out_data, e);
            $display("pop  data=%h expected=%h", out_data, e);
        end
        if (iv && !bypassed) begin
            if (n < DEPTH || popped_mem) exp_q.push_back(d);
            else evt = 1'b1;
        end
        if (evt) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(exp_q.size()));
        chk("almost_full", 32'(almost_full), 32'(exp_q.size() >= AFULL_LVL));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        $display("step in_valid=%0b in_data=%h out_ready=%0b clr=%0b count=%0d ovf=%0b",
                 iv, d, rdy, clr, count, overflow);
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        m_ovf        = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // First word after reset becomes visible one edge later.
        cycle(1'b1, 32'h11111111, 1'b0);
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_data", out_data, 32'h11111111);
        cycle(1'b0, 32'h0, 1'b1);

        // Overfill: 0xA4 is dropped and flagged.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0);
        repeat (5) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Full queue with simultaneous push and pop keeps 0xB0.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h90 + 32'(i), 1'b0);
        cycle(1'b1, 32'hB0, 1'b1);
        repeat (5) cycle(1'b0, 32'h0, 1'b1);

        // Streaming: one push and one pop every cycle.
        if (!BYP) cycle(1'b1, 32'hD00, 1'b0);
        for (int i = 1; i <= 10; i++) cycle(1'b1, 32'hD00 + 32'(i), 1'b1);
        repeat (2) cycle(1'b0, 32'h0, 1'b1);

        // Asynchronous reset mid-cycle with three words held.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hE0 + 32'(i), 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_almost_full", 32'(almost_full), 32'd0);
        exp_q.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Overflow, clear colliding with a new drop, then a plain clear.
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hF0 + 32'(i), 1'b0);
        cycle(1'b1, 32'hFF, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (5) cycle(1'b0, 32'h0, 1'b1);

        // Push into an empty queue with the consumer ready.
        cycle(1'b1, 32'hC0, 1'b1);
        repeat (2) cycle(1'b0, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
